// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants for the fetch-to-decode handoff.
package riscv_pkg;

    // Width of an instruction word and of a program counter.
    localparam int DATA_WIDTH = 32;

    // Canonical RV32 NOP (addi x0, x0, 0). Decode sees it whenever nothing is buffered.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Skid buffer fill level. Each state is one occupancy value.
    typedef enum logic [1:0] {
        FD_EMPTY = 2'd0,
        FD_ONE   = 2'd1,
        FD_FULL  = 2'd2
    } fd_state_e;

    // One buffered fetch result. The pc sits in the upper half.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instruction;
    } fd_entry_t;

    // Number of buffered entries held in a given fill state.
    function automatic logic [1:0] fd_occupancy(input fd_state_e state);
        logic [1:0] count;
        count = 2'd0;
        case (state)
            FD_ONE:  count = 2'd1;
            FD_FULL: count = 2'd2;
            default: count = 2'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Fetch-to-decode handshake bundle. Fetch drives f_*, decode consumes d_*.
// The modports give the controller's view of each side.
interface fetch_decode_if #(
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH
);

    // Fetch stage output side
    logic [DATA_WIDTH-1:0] f_instruction;
    logic [DATA_WIDTH-1:0] f_pc;
    logic                  f_valid;
    logic                  f_ready;

    // Decode stage input side
    logic [DATA_WIDTH-1:0] d_instruction;
    logic [DATA_WIDTH-1:0] d_pc;
    logic                  d_valid;
    logic                  d_ready;

    // Controller acting as the sink of the fetch stage's output
    modport fetch_out (
        input  f_instruction,
        input  f_pc,
        input  f_valid,
        output f_ready
    );

    // Controller acting as the source for the decode stage's input
    modport decode_in (
        output d_instruction,
        output d_pc,
        output d_valid,
        input  d_ready
    );

endinterface

// File: rtl/fd_skid_storage.sv
// Two-entry {pc, instruction} register array for the fetch/decode skid buffer.
// It is pure storage with one write port and one read port. The pointers and
// write enable come from the controller.
module fd_skid_storage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic             i_wr_ptr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_ptr,
    output logic [WIDTH-1:0] o_rd_data
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] r_data;

            // Capture the incoming entry when this slot is the write target.
            // Reset clears the slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (i_wr_en && (i_wr_ptr == 1'(gi))) begin
                    r_data <= i_wr_data;
                end
            end
        end
    endgenerate

    // The read port selects between the two registered slots.
    assign o_rd_data = i_rd_ptr ? g_entry[1].r_data : g_entry[0].r_data;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch-to-decode handoff controller. A 2-entry skid buffer decouples fetch
// from decode, so f_ready never depends on d_ready. Hazard stalls hold decode.
// Redirect flushes drop the buffered entries and count how many were dropped.
module fetch_decode_ctrl #(
    parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_decode_if.fetch_out    fetch_out,
    fetch_decode_if.decode_in    decode_in,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] flush_kills
);

    import riscv_pkg::*;

    localparam int ENTRY_W = 2 * DATA_WIDTH;

    // Registered control state
    fd_state_e            r_state;
    logic                 r_head;
    logic [CNT_WIDTH-1:0] r_flush_kills;

    // Handshake decode
    logic                 w_f_ready;
    logic                 w_d_valid;
    logic                 w_push;
    logic                 w_pop;

    // Storage access
    logic                 w_wr_ptr;
    logic [ENTRY_W-1:0]   w_wr_entry;
    logic [ENTRY_W-1:0]   w_rd_entry;

    // Kill counter arithmetic
    logic [1:0]           w_occupancy;
    logic [CNT_WIDTH:0]   w_kill_sum;
    logic [CNT_WIDTH-1:0] w_kill_next;

    // Fetch may push whenever there is room and no redirect is in progress.
    // Reset forces ready low without waiting for a clock.
    assign w_f_ready = rst_n && (r_state != FD_FULL) && !flush_i;
    assign w_push    = fetch_out.f_valid && w_f_ready;

    // Decode sees the head only when the hazard unit and redirect allow it.
    // A flush overrides a stall, and a stall overrides d_ready.
    assign w_d_valid = (r_state != FD_EMPTY) && !stall_i && !flush_i;
    assign w_pop     = w_d_valid && decode_in.d_ready;

    // A new entry goes into the slot after the current tail. When the buffer
    // is empty the tail is the head slot itself.
    assign w_wr_ptr   = (r_state == FD_EMPTY) ? r_head : ~r_head;
    assign w_wr_entry = {fetch_out.f_pc, fetch_out.f_instruction};

    fd_skid_storage #(
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_push),
        .i_wr_ptr  (w_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_ptr  (r_head),
        .o_rd_data (w_rd_entry)
    );

    // Occupancy follows the registered fill state, so it changes only at a
    // clock edge.
    assign w_occupancy = fd_occupancy(r_state);

    // Add the entries dropped by a flush to the counter. The counter sticks
    // at all-ones instead of wrapping.
    assign w_kill_sum  = {1'b0, r_flush_kills} + (CNT_WIDTH+1)'(w_occupancy);
    assign w_kill_next = w_kill_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                               : w_kill_sum[CNT_WIDTH-1:0];

    // Fill-state FSM with head pointer and flush-kill counter.
    // On a simultaneous push and pop in ONE, the new entry becomes the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FD_EMPTY;
            r_head        <= 1'b0;
            r_flush_kills <= '0;
        end else if (flush_i) begin
            r_state       <= FD_EMPTY;
            r_head        <= 1'b0;
            r_flush_kills <= w_kill_next;
        end else begin
            case (r_state)
                FD_EMPTY: begin
                    if (w_push) begin
                        r_state <= FD_ONE;
                    end
                end
                FD_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= ~r_head;
                    end else if (w_push) begin
                        r_state <= FD_FULL;
                    end else if (w_pop) begin
                        r_state <= FD_EMPTY;
                        r_head  <= ~r_head;
                    end
                end
                FD_FULL: begin
                    if (w_pop) begin
                        r_state <= FD_ONE;
                        r_head  <= ~r_head;
                    end
                end
                default: begin
                    r_state <= FD_EMPTY;
                    r_head  <= 1'b0;
                end
            endcase
        end
    end

    // Port mapping. When the buffer is empty, decode sees a NOP at pc 0
    // rather than stale storage.
    assign fetch_out.f_ready     = w_f_ready;
    assign decode_in.d_valid     = w_d_valid;
    assign decode_in.d_instruction = (r_state == FD_EMPTY) ? DATA_WIDTH'(NOP_INSTR)
                                                           : w_rd_entry[DATA_WIDTH-1:0];
    assign decode_in.d_pc        = (r_state == FD_EMPTY) ? '0
                                                         : w_rd_entry[ENTRY_W-1:DATA_WIDTH];
    assign occupancy             = w_occupancy;
    assign flush_kills           = r_flush_kills;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed, scoreboarded bench for fetch_decode_ctrl. A reference queue holds
// the entries that should be buffered. Accepted pushes are appended and
// delivered entries are popped and compared.
module tb_fetch_decode_ctrl;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int KMAX = (1 << CW) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          stall_i;
    logic          flush_i;
    logic [1:0]    occupancy;
    logic [CW-1:0] flush_kills;

    fetch_decode_if #(.DATA_WIDTH(DW)) bus ();

    fetch_decode_ctrl #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_out   (bus),
        .decode_in   (bus),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .occupancy   (occupancy),
        .flush_kills (flush_kills)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model
    logic [63:0] m_q[$];
    int          m_occ   = 0;
    int          m_kills = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the combinational and
    // registered outputs against the model, then advance the model
    // across the clock edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic st, input logic fl);
        logic        e_fr;
        logic        e_dv;
        logic        push;
        logic        pop;
        logic [63:0] head;
        bus.f_valid       = fv;
        bus.f_pc          = pc;
        bus.f_instruction = ins;
        bus.d_ready       = dr;
        stall_i           = st;
        flush_i           = fl;
        #1;
        e_fr = (m_occ != 2) && !fl;
        e_dv = (m_occ != 0) && !st && !fl;
        check("f_ready", {63'd0, bus.f_ready}, {63'd0, e_fr});
        check("d_valid", {63'd0, bus.d_valid}, {63'd0, e_dv});
        check("occupancy", {62'd0, occupancy}, 64'(m_occ));
        check("flush_kills", {60'd0, flush_kills}, 64'(m_kills));
        if (m_occ == 0) begin
            check("d_instruction_empty", {32'd0, bus.d_instruction}, {32'd0, NOP});
            check("d_pc_empty", {32'd0, bus.d_pc}, 64'd0);
        end else begin
            head = m_q[0];
            check("d_pc_head", {32'd0, bus.d_pc}, {32'd0, head[63:32]});
            check("d_instruction_head", {32'd0, bus.d_instruction}, {32'd0, head[31:0]});
        end
        push = fv && e_fr;
        pop  = e_dv && dr;
        @(posedge clk);
        if (fl) begin
            $display("flush: dropped %0d entries", m_occ);
            m_kills = (m_kills + m_occ > KMAX) ? KMAX : m_kills + m_occ;
            m_q.delete();
        end else begin
            if (pop) begin
                head = m_q.pop_front();
                $display("pop  pc=%h instr=%h", head[63:32], head[31:0]);
            end
            if (push) begin
                m_q.push_back({pc, ins});
                $display("push pc=%h instr=%h", pc, ins);
            end
        end
        m_occ = m_q.size();
        #1;
    endtask

    initial begin
        bus.f_valid       = 1'b0;
        bus.f_pc          = '0;
        bus.f_instruction = '0;
        bus.d_ready       = 1'b0;
        stall_i           = 1'b0;
        flush_i           = 1'b0;
        rst_n             = 1'b1;

        // Reset values, checked before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_f_ready", {63'd0, bus.f_ready}, 64'd0);
        check("rst_d_valid", {63'd0, bus.d_valid}, 64'd0);
        check("rst_d_instruction", {32'd0, bus.d_instruction}, {32'd0, NOP});
        check("rst_d_pc", {32'd0, bus.d_pc}, 64'd0);
        check("rst_occupancy", {62'd0, occupancy}, 64'd0);
        check("rst_flush_kills", {60'd0, flush_kills}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: f_ready=1, d_valid=0, NOP
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming with d_ready held high
        step(1'b1, 32'h00, 32'h0010_0093, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h04, 32'h0020_0113, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h08, 32'h0030_0193, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: stall with three offers, only two accepted
        step(1'b1, 32'h00, 32'hAAAA_0001, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h04, 32'hAAAA_0002, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b1, 1'b1, 1'b0);
        // Hold decode not ready for one cycle: head must stay put
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h08, 32'hAAAA_0003, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL, with fetch offering in the same cycle
        step(1'b1, 32'h10, 32'hBBBB_0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h14, 32'hBBBB_0002, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h18, 32'hBBBB_0003, 1'b1, 1'b0, 1'b1);
        check("kills_after_full_flush", {60'd0, flush_kills}, 64'd2);
        check("occ_after_full_flush", {62'd0, occupancy}, 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush during a stall while holding one entry
        step(1'b1, 32'h20, 32'hCCCC_0001, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("kills_after_one_flush", {60'd0, flush_kills}, 64'd3);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Drive the kill counter into saturation with repeated full flushes
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h100 + 32'(8*i), 32'hDD00_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
            step(1'b1, 32'h104 + 32'(8*i), 32'hDD10_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        check("kills_saturated", {60'd0, flush_kills}, 64'(KMAX));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset with two entries buffered, between clock edges
        step(1'b1, 32'h200, 32'hEEEE_0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h204, 32'hEEEE_0002, 1'b0, 1'b1, 1'b0);
        bus.f_valid = 1'b0;
        bus.d_ready = 1'b1;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_occupancy", {62'd0, occupancy}, 64'd0);
        check("arst_flush_kills", {60'd0, flush_kills}, 64'd0);
        check("arst_f_ready", {63'd0, bus.f_ready}, 64'd0);
        check("arst_d_valid", {63'd0, bus.d_valid}, 64'd0);
        check("arst_d_instruction", {32'd0, bus.d_instruction}, {32'd0, NOP});
        check("arst_d_pc", {32'd0, bus.d_pc}, 64'd0);
        $display("async reset: dropped %0d entries", m_occ);
        m_q.delete();
        m_occ   = 0;
        m_kills = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Traffic resumes normally after reset
        step(1'b1, 32'h300, 32'hFFFF_0001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'hFFFF_0002, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
